// File: rtl/prbs_sym_src_pkg.sv
// -----------------------------------------------------------------------------
// prbs_sym_src_pkg
// Shared constants for the PRBS symbol source: standard Fibonacci tap masks
// and the default parameter values used by prbs_sym_src and prbs_lfsr.
// Tap mask bit i selects state bit i into the feedback XOR.
// -----------------------------------------------------------------------------
package prbs_sym_src_pkg;

    // x^7 + x^6 + 1
    localparam logic [6:0]  TAPS_PRBS7  = 7'h60;
    // x^9 + x^5 + 1
    localparam logic [8:0]  TAPS_PRBS9  = 9'h110;
    // x^15 + x^14 + 1
    localparam logic [14:0] TAPS_PRBS15 = 15'h6000;

    localparam int DEF_LFSR_W   = 7;
    localparam int DEF_SYM_W    = 4;
    localparam int DEF_DIV_W    = 8;
    localparam int DEF_SEED_RST = 1;
    localparam int CNT_W        = 16;

endpackage

// File: rtl/prbs_lfsr.sv
// -----------------------------------------------------------------------------
// prbs_lfsr
// Fibonacci LFSR with seed load and lock-up guard.
//
// Ports
//   clk      in  clock, all state on posedge
//   reset    in  synchronous active-high reset, state <= SEED_RST
//   step_i   in  advance the LFSR by one step
//   load_i   in  load seed_i (zero seed is replaced by 1); beats step_i
//   seed_i   in  seed value
//   state_o  out current LFSR state
//   next_o   out state after one step (combinational from state_o)
// -----------------------------------------------------------------------------
module prbs_lfsr
    import prbs_sym_src_pkg::*;
#(
    parameter int              W        = DEF_LFSR_W,
    parameter logic [W-1:0]    TAPS     = W'(TAPS_PRBS7),
    parameter logic [W-1:0]    SEED_RST = W'(DEF_SEED_RST)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step_i,
    input  logic         load_i,
    input  logic [W-1:0] seed_i,
    output logic [W-1:0] state_o,
    output logic [W-1:0] next_o
);

    logic [W-1:0] state_q, state_d;

    assign next_o  = {state_q[W-2:0], ^(state_q & TAPS)};
    assign state_o = state_q;

    always_comb begin
        // NOTE: default assignment first so every path assigns state_d; otherwise a latch is inferred.
        state_d = state_q;
        if (load_i) begin
            state_d = (seed_i == '0) ? W'(1) : seed_i;
        end else if (state_q == '0) begin
            // All-zero is a fixed point of the XOR feedback; kick it out.
            state_d = W'(1);
        end else if (step_i) begin
            state_d = next_o;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (reset) begin
            state_q <= SEED_RST;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/prbs_sym_src.sv
// -----------------------------------------------------------------------------
// prbs_sym_src
// Rate-controlled PRBS symbol source with a one-entry valid/ready output slot.
// A tick counter fires every div_i+1 enabled clocks; each tick that finds the
// output slot free steps the LFSR and presents the low SYM_W bits of the new
// state. A tick that finds the slot occupied waits (counter holds) so symbols
// are never dropped or repeated.
//
// Ports
//   clk          in  clock
//   reset        in  synchronous active-high reset, highest priority
//   enable_i     in  run enable; low freezes tick counter and LFSR
//   div_i        in  symbol period minus one, in clocks
//   load_i       in  one-cycle seed load strobe; clears counter and slot
//   seed_i       in  seed for load_i
//   sym_o        out current symbol
//   sym_valid_o  out sym_o holds an unconsumed symbol
//   sym_ready_i  in  downstream accepts sym_o this cycle
//   sym_count_o  out accepted-symbol count, wraps at 2^16
// -----------------------------------------------------------------------------
module prbs_sym_src
    import prbs_sym_src_pkg::*;
#(
    parameter int                  LFSR_W   = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0]   TAPS     = LFSR_W'(TAPS_PRBS7),
    parameter int                  SYM_W    = DEF_SYM_W,
    parameter int                  DIV_W    = DEF_DIV_W,
    parameter logic [LFSR_W-1:0]   SEED_RST = LFSR_W'(DEF_SEED_RST)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic [SYM_W-1:0]  sym_o,
    output logic              sym_valid_o,
    input  logic              sym_ready_i,
    output logic [CNT_W-1:0]  sym_count_o
);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [SYM_W-1:0]  sym_q, sym_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              tick;
    logic              slot_free;
    logic              accept;
    logic              step;
    logic [LFSR_W-1:0] lfsr_state;
    logic [LFSR_W-1:0] lfsr_next;

    // State is exposed for observation only and the upper next bits are not
    // part of the symbol; fold them into one sink.
    logic              unused_bits;
    assign unused_bits = ^{lfsr_state, lfsr_next};

    assign accept    = valid_q & sym_ready_i;
    assign slot_free = ~valid_q | sym_ready_i;
    // '>=' rather than '==' so shrinking div_i mid-count ticks immediately.
    assign tick      = enable_i & (cnt_q >= div_i);
    assign step      = tick & slot_free & ~load_i;

    prbs_lfsr #(
        .W        (LFSR_W),
        .TAPS     (TAPS),
        .SEED_RST (SEED_RST)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .step_i  (step),
        .load_i  (load_i),
        .seed_i  (seed_i),
        .state_o (lfsr_state),
        .next_o  (lfsr_next)
    );

    always_comb begin
        cnt_d   = cnt_q;
        sym_d   = sym_q;
        valid_d = valid_q;
        // A handshake completes regardless of load_i, so it always counts.
        count_d = count_q + CNT_W'(accept);

        if (load_i) begin
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            if (enable_i) begin
                if (tick) begin
                    // Blocked tick keeps cnt at its tick value so it retries.
                    if (slot_free) begin
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            if (step) begin
                sym_d   = lfsr_next[SYM_W-1:0];
                valid_d = 1'b1;
            end else if (accept) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            sym_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign sym_o       = sym_q;
    assign sym_valid_o = valid_q;
    assign sym_count_o = count_q;

endmodule

// File: tb/tb_prbs_sym_src.sv
// -----------------------------------------------------------------------------
// tb_prbs_sym_src
// Directed bench for prbs_sym_src with default parameters (PRBS7, 4-bit
// symbols). Expected PRBS7 symbols from seed 1, hand-derived:
//   state : 02 04 08 10 20 41 03 06 0C 18 30 61
//   sym   :  2  4  8  0  0  1  3  6  C  8  0  1
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_prbs_sym_src;

    localparam int LFSR_W = 7;
    localparam int SYM_W  = 4;
    localparam int DIV_W  = 8;

    logic              clk;
    logic              reset;
    logic              enable_i;
    logic [DIV_W-1:0]  div_i;
    logic              load_i;
    logic [LFSR_W-1:0] seed_i;
    logic [SYM_W-1:0]  sym_o;
    logic              sym_valid_o;
    logic              sym_ready_i;
    logic [15:0]       sym_count_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [3:0] seq_exp [0:11] = '{4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h1,
                                   4'h3, 4'h6, 4'hC, 4'h8, 4'h0, 4'h1};

    prbs_sym_src dut (
        .clk         (clk),
        .reset       (reset),
        .enable_i    (enable_i),
        .div_i       (div_i),
        .load_i      (load_i),
        .seed_i      (seed_i),
        .sym_o       (sym_o),
        .sym_valid_o (sym_valid_o),
        .sym_ready_i (sym_ready_i),
        .sym_count_o (sym_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after the last reset edge; the next edge is edge 1.
    task automatic apply_reset(input logic [DIV_W-1:0] div, input logic rdy);
        reset       = 1'b1;
        load_i      = 1'b0;
        seed_i      = '0;
        enable_i    = 1'b1;
        div_i       = div;
        sym_ready_i = rdy;
        repeat (2) next_edge();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(8'd0, 1'b1);
        total_cnt++;
        if (sym_o !== 4'h0) $display("FAIL reset_sym: got %0h expected 0", sym_o);
        else pass_cnt++;
        total_cnt++;
        if (sym_valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", sym_valid_o);
        else pass_cnt++;
        total_cnt++;
        if (sym_count_o !== 16'h0) $display("FAIL reset_count: got %0h expected 0", sym_count_o);
        else pass_cnt++;
        total_cnt++;
        if (dut.u_lfsr.state_o !== 7'h01) $display("FAIL reset_state: got %0h expected 01", dut.u_lfsr.state_o);
        else pass_cnt++;
    endtask

    task automatic test_sequence();
        apply_reset(8'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            next_edge();
            total_cnt++;
            if (sym_valid_o !== 1'b1 || sym_o !== seq_exp[i])
                $display("FAIL seq[%0d]: got valid=%b sym=%0h expected valid=1 sym=%0h", i, sym_valid_o, sym_o, seq_exp[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (sym_count_o !== 16'd5) $display("FAIL seq_count: got %0d expected 5", sym_count_o);
        else pass_cnt++;
    endtask

    task automatic test_rate();
        logic exp_v;
        apply_reset(8'd10, 1'b1);
        for (int e = 1; e <= 22; e++) begin
            next_edge();
            exp_v = (e == 11 || e == 22);
            total_cnt++;
            if (sym_valid_o !== exp_v) $display("FAIL rate_valid@%0d: got %b expected %b", e, sym_valid_o, exp_v);
            else pass_cnt++;
            if (exp_v) begin
                total_cnt++;
                if (sym_o !== ((e == 11) ? seq_exp[0] : seq_exp[1]))
                    $display("FAIL rate_sym@%0d: got %0h expected %0h", e, sym_o, (e == 11) ? seq_exp[0] : seq_exp[1]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_div_shrink();
        apply_reset(8'd10, 1'b1);
        repeat (5) next_edge();
        total_cnt++;
        if (sym_valid_o !== 1'b0) $display("FAIL shrink_pre_valid: got %b expected 0", sym_valid_o);
        else pass_cnt++;
        div_i = 8'd2;
        next_edge();
        total_cnt++;
        if (sym_valid_o !== 1'b1 || sym_o !== 4'h2)
            $display("FAIL shrink_tick: got valid=%b sym=%0h expected valid=1 sym=2", sym_valid_o, sym_o);
        else pass_cnt++;
    endtask

    task automatic test_back_pressure();
        apply_reset(8'd0, 1'b1);
        repeat (3) next_edge();
        sym_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_edge();
            total_cnt++;
            if (sym_valid_o !== 1'b1 || sym_o !== 4'h8 || dut.u_lfsr.state_o !== 7'h08)
                $display("FAIL stall[%0d]: got valid=%b sym=%0h state=%0h expected valid=1 sym=8 state=08", i, sym_valid_o, sym_o, dut.u_lfsr.state_o);
            else pass_cnt++;
        end
        sym_ready_i = 1'b1;
        for (int i = 3; i < 7; i++) begin
            next_edge();
            total_cnt++;
            if (sym_valid_o !== 1'b1 || sym_o !== seq_exp[i])
                $display("FAIL resume[%0d]: got valid=%b sym=%0h expected valid=1 sym=%0h", i, sym_valid_o, sym_o, seq_exp[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (sym_count_o !== 16'd6) $display("FAIL stall_count: got %0d expected 6", sym_count_o);
        else pass_cnt++;
    endtask

    task automatic test_enable();
        apply_reset(8'd0, 1'b0);
        next_edge();
        enable_i = 1'b0;
        repeat (2) next_edge();
        total_cnt++;
        if (sym_valid_o !== 1'b1 || sym_o !== 4'h2)
            $display("FAIL en_hold: got valid=%b sym=%0h expected valid=1 sym=2", sym_valid_o, sym_o);
        else pass_cnt++;
        sym_ready_i = 1'b1;
        repeat (3) next_edge();
        total_cnt++;
        if (sym_valid_o !== 1'b0 || sym_count_o !== 16'd1 || dut.u_lfsr.state_o !== 7'h02)
            $display("FAIL en_frozen: got valid=%b count=%0d state=%0h expected valid=0 count=1 state=02", sym_valid_o, sym_count_o, dut.u_lfsr.state_o);
        else pass_cnt++;
        enable_i = 1'b1;
        next_edge();
        total_cnt++;
        if (sym_valid_o !== 1'b1 || sym_o !== 4'h4)
            $display("FAIL en_resume: got valid=%b sym=%0h expected valid=1 sym=4", sym_valid_o, sym_o);
        else pass_cnt++;
    endtask

    task automatic test_load();
        apply_reset(8'd0, 1'b1);
        repeat (3) next_edge();
        load_i = 1'b1;
        seed_i = 7'h00;
        next_edge();
        load_i = 1'b0;
        total_cnt++;
        if (dut.u_lfsr.state_o !== 7'h01 || sym_valid_o !== 1'b0 || sym_count_o !== 16'd3)
            $display("FAIL load_zero: got state=%0h valid=%b count=%0d expected state=01 valid=0 count=3", dut.u_lfsr.state_o, sym_valid_o, sym_count_o);
        else pass_cnt++;
        next_edge();
        total_cnt++;
        if (sym_valid_o !== 1'b1 || sym_o !== 4'h2 || sym_count_o !== 16'd3)
            $display("FAIL load_zero_next: got valid=%b sym=%0h count=%0d expected valid=1 sym=2 count=3", sym_valid_o, sym_o, sym_count_o);
        else pass_cnt++;
        load_i = 1'b1;
        seed_i = 7'h55;
        next_edge();
        load_i = 1'b0;
        total_cnt++;
        if (dut.u_lfsr.state_o !== 7'h55 || sym_valid_o !== 1'b0 || sym_count_o !== 16'd4)
            $display("FAIL load_55: got state=%0h valid=%b count=%0d expected state=55 valid=0 count=4", dut.u_lfsr.state_o, sym_valid_o, sym_count_o);
        else pass_cnt++;
        next_edge();
        total_cnt++;
        if (sym_valid_o !== 1'b1 || sym_o !== 4'hB || dut.u_lfsr.state_o !== 7'h2B)
            $display("FAIL load_55_next: got valid=%b sym=%0h state=%0h expected valid=1 sym=b state=2b", sym_valid_o, sym_o, dut.u_lfsr.state_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        apply_reset(8'd0, 1'b1);
        repeat (3) next_edge();
        sym_ready_i = 1'b0;
        next_edge();
        reset = 1'b1;
        next_edge();
        total_cnt++;
        if (sym_o !== 4'h0 || sym_valid_o !== 1'b0 || sym_count_o !== 16'h0 || dut.u_lfsr.state_o !== 7'h01)
            $display("FAIL reset_mid: got sym=%0h valid=%b count=%0d state=%0h expected 0 0 0 01", sym_o, sym_valid_o, sym_count_o, dut.u_lfsr.state_o);
        else pass_cnt++;
        reset       = 1'b0;
        sym_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            next_edge();
            total_cnt++;
            if (sym_valid_o !== 1'b1 || sym_o !== seq_exp[i])
                $display("FAIL restart[%0d]: got valid=%b sym=%0h expected valid=1 sym=%0h", i, sym_valid_o, sym_o, seq_exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_period_and_wrap();
        logic seen_early;
        seen_early = 1'b0;
        apply_reset(8'd0, 1'b1);
        for (int e = 1; e < 127; e++) begin
            next_edge();
            if (dut.u_lfsr.state_o === 7'h01) seen_early = 1'b1;
        end
        total_cnt++;
        if (seen_early !== 1'b0) $display("FAIL period_short: got early return to seed expected none");
        else pass_cnt++;
        next_edge();
        total_cnt++;
        if (dut.u_lfsr.state_o !== 7'h01) $display("FAIL period_127: got state=%0h expected 01", dut.u_lfsr.state_o);
        else pass_cnt++;
        next_edge();
        total_cnt++;
        if (sym_count_o !== 16'd127) $display("FAIL period_count: got %0d expected 127", sym_count_o);
        else pass_cnt++;
        repeat (65536 - 128) next_edge();
        total_cnt++;
        if (sym_count_o !== 16'hFFFF) $display("FAIL wrap_pre: got %0h expected ffff", sym_count_o);
        else pass_cnt++;
        next_edge();
        total_cnt++;
        if (sym_count_o !== 16'h0000) $display("FAIL wrap: got %0h expected 0", sym_count_o);
        else pass_cnt++;
    endtask

    initial begin
        reset       = 1'b1;
        enable_i    = 1'b0;
        div_i       = '0;
        load_i      = 1'b0;
        seed_i      = '0;
        sym_ready_i = 1'b0;

        test_reset();
        test_sequence();
        test_rate();
        test_div_shrink();
        test_back_pressure();
        test_enable();
        test_load();
        test_reset_mid();
        test_period_and_wrap();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
